// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// This block shares one 32-bit memory port between two requesters: instruction
// fetch (IF) and load/store (D). Each access goes through a small FSM:
//   IDLE -> ACC_IF or ACC_D -> RESP -> IDLE
//
// The winner's address, write enable and write data are latched into MEM_*.
// MEM_SEL drives the select of the address 2:1 mux in front of memory
// (1 = data path, 0 = fetch path). Read data and a one-cycle completion pulse
// go back to the requester that was served.
//
// Every output comes from a flop. No input has a combinational path to any
// output.
//
// Configuration macro: MEM_ARB_RR_EN
//   defined   - round-robin on simultaneous requests; the requester that was
//               not served most recently wins
//   undefined - fixed priority; D wins every tie
//
// Parameters:
//   AW - address width
//   DW - data width
//
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   IF_REQ, IF_ADDR             fetch request (level) and address
//   IF_GNT, IF_DONE, IF_RDATA   fetch grant pulse, done pulse, read data
//   D_REQ, D_WE, D_ADDR, D_WDATA  data request, write enable, address, write data
//   D_GNT, D_DONE, D_RDATA      data grant pulse, done pulse, read data
//   MEM_SEL                     address mux select (1 = D, 0 = IF)
//   MEM_EN, MEM_WE              access strobe, write enable
//   MEM_ADDR, MEM_WDATA         latched access address and write data
//   MEM_RDATA, MEM_READY        memory read data; access completes this cycle

module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          IF_REQ,
    input  logic [AW-1:0] IF_ADDR,
    output logic          IF_GNT,
    output logic          IF_DONE,
    output logic [DW-1:0] IF_RDATA,
    input  logic          D_REQ,
    input  logic          D_WE,
    input  logic [AW-1:0] D_ADDR,
    input  logic [DW-1:0] D_WDATA,
    output logic          D_GNT,
    output logic          D_DONE,
    output logic [DW-1:0] D_RDATA,
    output logic          MEM_SEL,
    output logic          MEM_EN,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    input  logic [DW-1:0] MEM_RDATA,
    input  logic          MEM_READY
);

    typedef enum logic [1:0] {
        IDLE,
        ACC_IF,
        ACC_D,
        RESP
    } state_t;

    state_t        state, state_nxt;
    logic          pick_d;
    logic          if_gnt_nxt, if_done_nxt, d_gnt_nxt, d_done_nxt;
    logic          mem_sel_nxt, mem_en_nxt, mem_we_nxt;
    logic [AW-1:0] mem_addr_nxt;
    logic [DW-1:0] mem_wdata_nxt, if_rdata_nxt, d_rdata_nxt;

`ifdef MEM_ARB_RR_EN
    // last_d is 1 when D was the most recent requester granted.
    // Reset leaves it at 0, meaning IF was served last.
    logic last_d, last_d_nxt;
    assign pick_d = D_REQ && (!IF_REQ || !last_d);
`else
    assign pick_d = D_REQ;
`endif

    // Next-state logic and next values for the registered outputs.
    // Outputs are produced one cycle ahead so that every output is a flop:
    //   GNT is set on entry to ACC,
    //   DONE is set on entry to RESP.
    always_comb begin
        state_nxt     = state;
        if_gnt_nxt    = 1'b0;
        if_done_nxt   = 1'b0;
        d_gnt_nxt     = 1'b0;
        d_done_nxt    = 1'b0;
        mem_en_nxt    = 1'b0;
        mem_sel_nxt   = MEM_SEL;
        mem_we_nxt    = MEM_WE;
        mem_addr_nxt  = MEM_ADDR;
        mem_wdata_nxt = MEM_WDATA;
        if_rdata_nxt  = IF_RDATA;
        d_rdata_nxt   = D_RDATA;
`ifdef MEM_ARB_RR_EN
        last_d_nxt    = last_d;
`endif
        case (state)
            IDLE: begin
                if (IF_REQ || D_REQ) begin
                    mem_en_nxt = 1'b1;
                    if (pick_d) begin
                        state_nxt     = ACC_D;
                        d_gnt_nxt     = 1'b1;
                        mem_sel_nxt   = 1'b1;
                        mem_we_nxt    = D_WE;
                        mem_addr_nxt  = D_ADDR;
                        mem_wdata_nxt = D_WDATA;
`ifdef MEM_ARB_RR_EN
                        last_d_nxt    = 1'b1;
`endif
                    end else begin
                        state_nxt     = ACC_IF;
                        if_gnt_nxt    = 1'b1;
                        mem_sel_nxt   = 1'b0;
                        mem_we_nxt    = 1'b0;
                        mem_addr_nxt  = IF_ADDR;
                        mem_wdata_nxt = '0;
`ifdef MEM_ARB_RR_EN
                        last_d_nxt    = 1'b0;
`endif
                    end
                end
            end
            ACC_IF: begin
                if (MEM_READY) begin
                    state_nxt    = RESP;
                    if_done_nxt  = 1'b1;
                    if_rdata_nxt = MEM_RDATA;
                end else begin
                    mem_en_nxt = 1'b1;
                end
            end
            ACC_D: begin
                if (MEM_READY) begin
                    state_nxt   = RESP;
                    d_done_nxt  = 1'b1;
                    d_rdata_nxt = MEM_RDATA;
                end else begin
                    mem_en_nxt = 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers.
    // Reset clears everything. A reset during an access abandons it, so no
    // DONE pulse is issued for that access.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            IF_GNT    <= 1'b0;
            IF_DONE   <= 1'b0;
            IF_RDATA  <= '0;
            D_GNT     <= 1'b0;
            D_DONE    <= 1'b0;
            D_RDATA   <= '0;
            MEM_SEL   <= 1'b0;
            MEM_EN    <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
`ifdef MEM_ARB_RR_EN
            last_d    <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            IF_GNT    <= if_gnt_nxt;
            IF_DONE   <= if_done_nxt;
            IF_RDATA  <= if_rdata_nxt;
            D_GNT     <= d_gnt_nxt;
            D_DONE    <= d_done_nxt;
            D_RDATA   <= d_rdata_nxt;
            MEM_SEL   <= mem_sel_nxt;
            MEM_EN    <= mem_en_nxt;
            MEM_WE    <= mem_we_nxt;
            MEM_ADDR  <= mem_addr_nxt;
            MEM_WDATA <= mem_wdata_nxt;
`ifdef MEM_ARB_RR_EN
            last_d    <= last_d_nxt;
`endif
        end
    end

endmodule
